// File: rtl/issue_scoreboard.sv
// Per-warp register scoreboard: holds the instruction-buffer head while any of its
// registers has a write in flight, and releases it downstream with valid/ready.
module issue_scoreboard #(
  parameter int NUM_WARPS     = 4,
  parameter int NUM_REGS      = 64,
  parameter int STALL_TIMEOUT = 100000,
  localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NR_BITS      = $clog2(NUM_REGS),
  localparam int CNT_BITS     = $clog2(STALL_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ibuf_valid,
  output logic               ibuf_ready,
  input  logic [NW_BITS-1:0] ibuf_wid,
  input  logic               ibuf_wb,
  input  logic [NR_BITS-1:0] ibuf_rd,
  input  logic [NR_BITS-1:0] ibuf_rs1,
  input  logic [NR_BITS-1:0] ibuf_rs2,
  input  logic [NR_BITS-1:0] ibuf_rs3,
  input  logic [NW_BITS-1:0] ibuf_wid_n,
  input  logic [NR_BITS-1:0] ibuf_rd_n,
  input  logic [NR_BITS-1:0] ibuf_rs1_n,
  input  logic [NR_BITS-1:0] ibuf_rs2_n,
  input  logic [NR_BITS-1:0] ibuf_rs3_n,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               wb_valid,
  input  logic [NW_BITS-1:0] wb_wid,
  input  logic [NR_BITS-1:0] wb_rd,
  input  logic               wb_eop,
  output logic               deadlock
);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse_reg;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse_next;
  logic                               hazard_reg;
  logic                               hazard_next;
  logic [CNT_BITS-1:0]                stall_cnt_reg;
  logic [CNT_BITS-1:0]                stall_cnt_next;
  logic                               deadlock_reg;
  logic                               deadlock_next;
  logic                               fire;
  logic                               reserve;
  logic                               release_en;
  logic [NUM_REGS-1:0]                look_row;
  logic                               unused_head_srcs;

  assign fire       = ibuf_valid && out_ready && !hazard_reg;
  assign out_valid  = ibuf_valid && !hazard_reg;
  assign ibuf_ready = out_ready && !hazard_reg;
  assign reserve    = fire && ibuf_wb && (ibuf_rd != '0);
  assign release_en = wb_valid && wb_eop;
  assign deadlock   = deadlock_reg;

  // Head sources are already covered by the lookahead copies checked last cycle.
  assign unused_head_srcs = ^{ibuf_rs1, ibuf_rs2, ibuf_rs3};

  // Release first, reserve second, so a same-entry collision leaves the entry busy.
  generate
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      logic [NUM_REGS-1:0] row_next;

      always_comb begin
        row_next = inuse_reg[gi];
        if (release_en && (wb_wid == NW_BITS'(gi)))
          row_next[wb_rd] = 1'b0;
        if (reserve && (ibuf_wid == NW_BITS'(gi)))
          row_next[ibuf_rd] = 1'b1;
        row_next[0] = 1'b0;
      end

      assign inuse_next[gi] = row_next;
    end
  endgenerate

  // Looking up the next-cycle head in the post-update table avoids a release bubble.
  assign look_row    = inuse_next[ibuf_wid_n];
  assign hazard_next = look_row[ibuf_rd_n] | look_row[ibuf_rs1_n]
                     | look_row[ibuf_rs2_n] | look_row[ibuf_rs3_n];

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (fire || !(ibuf_valid && hazard_reg))
      stall_cnt_next = '0;
    else if (stall_cnt_reg != CNT_BITS'(STALL_TIMEOUT))
      stall_cnt_next = stall_cnt_reg + CNT_BITS'(1);
    deadlock_next = deadlock_reg || (stall_cnt_next == CNT_BITS'(STALL_TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inuse_reg     <= '0;
      hazard_reg    <= 1'b0;
      stall_cnt_reg <= '0;
      deadlock_reg  <= 1'b0;
    end else begin
      inuse_reg     <= inuse_next;
      hazard_reg    <= hazard_next;
      stall_cnt_reg <= stall_cnt_next;
      deadlock_reg  <= deadlock_next;
    end
  end

  // A final writeback for a register that was never reserved indicates lost tracking.
  always_ff @(posedge clk) begin
    if (!reset && release_en && (wb_rd != '0))
      assert (inuse_reg[wb_wid][wb_rd]);
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected issues are queued as stimulus is
// driven and popped when the handshake fires; hazard/deadlock timing is checked per cycle.
module tb_issue_scoreboard;

  logic       clk;
  logic       reset;
  logic       ibuf_valid;
  logic       ibuf_ready;
  logic [1:0] ibuf_wid;
  logic       ibuf_wb;
  logic [5:0] ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
  logic [1:0] ibuf_wid_n;
  logic [5:0] ibuf_rd_n, ibuf_rs1_n, ibuf_rs2_n, ibuf_rs3_n;
  logic       out_valid;
  logic       out_ready;
  logic       wb_valid;
  logic [1:0] wb_wid;
  logic [5:0] wb_rd;
  logic       wb_eop;
  logic       deadlock;

  int n_cmp = 0;
  int n_err = 0;
  int n_fire = 0;
  logic [7:0] exp_q[$];

  issue_scoreboard #(
    .NUM_WARPS(4), .NUM_REGS(64), .STALL_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready),
    .ibuf_wid(ibuf_wid), .ibuf_wb(ibuf_wb),
    .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3),
    .ibuf_wid_n(ibuf_wid_n), .ibuf_rd_n(ibuf_rd_n),
    .ibuf_rs1_n(ibuf_rs1_n), .ibuf_rs2_n(ibuf_rs2_n), .ibuf_rs3_n(ibuf_rs3_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
    .deadlock(deadlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic head(input bit v, input int w, input bit wb, input int rd,
                      input int r1, input int r2, input int r3);
    ibuf_valid = v;
    ibuf_wid   = 2'(w);
    ibuf_wb    = wb;
    ibuf_rd    = 6'(rd);
    ibuf_rs1   = 6'(r1);
    ibuf_rs2   = 6'(r2);
    ibuf_rs3   = 6'(r3);
  endtask

  task automatic look(input int w, input int rd, input int r1, input int r2, input int r3);
    ibuf_wid_n = 2'(w);
    ibuf_rd_n  = 6'(rd);
    ibuf_rs1_n = 6'(r1);
    ibuf_rs2_n = 6'(r2);
    ibuf_rs3_n = 6'(r3);
  endtask

  task automatic wb(input bit v, input int w, input int rd, input bit eop);
    wb_valid = v;
    wb_wid   = 2'(w);
    wb_rd    = 6'(rd);
    wb_eop   = eop;
  endtask

  task automatic push(input int w, input int rd);
    exp_q.push_back({2'(w), 6'(rd)});
  endtask

  // One cycle: check handshake mid-cycle, retire any fire against the queue, advance.
  task automatic tick(input string tag, input bit go);
    logic [7:0] e;
    #2;
    check({tag, "_out_valid"}, int'(out_valid), int'(ibuf_valid && go));
    check({tag, "_ibuf_ready"}, int'(ibuf_ready), int'(out_ready && go));
    if (ibuf_valid && out_valid && out_ready) begin
      n_fire++;
      $display("issue w%0d rd%0d (%s)", ibuf_wid, ibuf_rd, tag);
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_issue"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_issue_id"}, int'({ibuf_wid, ibuf_rd}), int'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fires_before;
    reset = 1'b1;
    out_ready = 1'b0;
    head(0, 0, 0, 0, 0, 0, 0);
    look(0, 0, 0, 0, 0);
    wb(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;

    // Reset state
    check("reset_deadlock", int'(deadlock), 0);
    for (int w = 0; w < 4; w++)
      check($sformatf("reset_table_w%0d", w), int'(dut.inuse_reg[w] != '0), 0);
    look(0, 1, 0, 0, 0);
    tick("reset_idle", 1);

    // Independent back-to-back stream on warp 0
    fires_before = n_fire;
    head(1, 0, 1, 1, 0, 0, 0);    look(0, 2, 10, 11, 12); push(0, 1); tick("ind1", 1);
    head(1, 0, 1, 2, 10, 11, 12); look(0, 3, 13, 0, 0);   push(0, 2); tick("ind2", 1);
    head(1, 0, 1, 3, 13, 0, 0);   look(0, 5, 0, 0, 0);    push(0, 3); tick("ind3", 1);
    check("ind_fires", n_fire - fires_before, 3);
    for (int r = 1; r <= 3; r++)
      check($sformatf("ind_busy_r%0d", r), int'(dut.inuse_reg[0][r]), 1);

    // RAW stall: release on the 10th stalled cycle, issue the cycle after
    head(1, 0, 1, 5, 0, 0, 0); look(0, 6, 5, 0, 0); push(0, 5); tick("raw_issue", 1);
    head(1, 0, 1, 6, 5, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4)      wb(1, 0, 5, 0);
      else if (i == 9) wb(1, 0, 5, 1);
      else             wb(0, 0, 0, 0);
      tick($sformatf("raw_stall%0d", i), 0);
    end
    wb(0, 0, 0, 0);
    look(1, 7, 0, 0, 0); push(0, 6); tick("raw_release", 1);
    check("raw_no_deadlock", int'(deadlock), 0);

    // Cross-warp independence
    head(1, 1, 1, 7, 0, 0, 0);  look(2, 20, 7, 0, 0); push(1, 7);  tick("xwarp_reserve", 1);
    head(1, 2, 1, 20, 7, 0, 0); look(0, 0, 0, 0, 0);  push(2, 20); tick("xwarp_issue", 1);
    check("xwarp_busy_w1r7", int'(dut.inuse_reg[1][7]), 1);

    // Register 0 is never reserved
    head(1, 0, 1, 0, 0, 0, 0);  look(0, 22, 0, 0, 0); push(0, 0);  tick("x0_reserve", 1);
    head(1, 0, 1, 22, 0, 0, 0); look(3, 9, 0, 0, 0);  push(0, 22); tick("x0_issue", 1);
    check("x0_never_busy", int'(dut.inuse_reg[0][0]), 0);

    // Forced same-cycle release and reserve of (3,9): reserve wins
    head(1, 3, 1, 9, 0, 0, 0); look(3, 30, 31, 32, 33); push(3, 9); tick("coll_reserve", 1);
    wb(1, 3, 9, 1);
    look(3, 0, 9, 0, 0); push(3, 9); tick("coll_fire", 1);
    wb(0, 0, 0, 0);
    check("coll_entry_set", int'(dut.inuse_reg[3][9]), 1);
    head(0, 0, 0, 0, 0, 0, 0); look(0, 4, 0, 0, 0); tick("coll_hazard", 0);

    // Deadlock after 16 consecutive stalled cycles, sticky until reset
    head(1, 0, 1, 4, 0, 0, 0); look(0, 23, 0, 4, 0); push(0, 4); tick("dl_reserve", 1);
    head(1, 0, 1, 23, 0, 4, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("dl_clear_%0d", i), int'(deadlock), 0);
      tick("dl_stall", 0);
    end
    check("dl_set", int'(deadlock), 1);
    repeat (3) tick("dl_hold", 0);
    head(0, 0, 0, 0, 0, 0, 0); out_ready = 1'b0;
    tick("dl_idle", 0);
    check("dl_sticky", int'(deadlock), 1);

    // Reset mid-operation clears reservations and the flag
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    check("rst2_deadlock", int'(deadlock), 0);
    check("rst2_w0r4", int'(dut.inuse_reg[0][4]), 0);
    check("rst2_w3r9", int'(dut.inuse_reg[3][9]), 0);
    head(1, 0, 0, 23, 0, 4, 0); look(0, 0, 0, 0, 0); push(0, 23); tick("rst2_issue", 1);
    head(0, 0, 0, 0, 0, 0, 0); tick("rst2_idle", 1);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
